// File: rtl/argmax_ang.sv
// argmax_ang: per-window argmax of a metric stream, reporting the winning sample's angle, index and metric.
module argmax_ang #(
  parameter int N_WIN = 256,
  parameter int MW = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [MW-1:0]              metric_in,
  input  logic signed [12:0]         ang_in,
  output logic signed [12:0]         ang_out,
  output logic [$clog2(N_WIN)-1:0]   theta_out,
  output logic [MW-1:0]              max_out,
  output logic                       argmax_valid
);
  localparam int IW = $clog2(N_WIN);
  localparam logic [IW-1:0] LAST = IW'(N_WIN - 1);
  typedef enum logic {SCAN, EMIT} state_t;
  state_t state_q;
  logic [IW-1:0] idx_q, best_idx_q, best_idx_d;
  logic [MW-1:0] best_metric_q, best_metric_d;
  logic signed [12:0] best_ang_q, best_ang_d;
  logic take;
  // Strict compare keeps the earliest index on ties; idx 0 always reloads.
  always_comb begin
    take = (idx_q == '0) || (metric_in > best_metric_q);
    best_metric_d = take ? metric_in : best_metric_q;
    best_ang_d = take ? ang_in : best_ang_q;
    best_idx_d = take ? idx_q : best_idx_q;
  end
  assign argmax_valid = (state_q == EMIT);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCAN;
      idx_q <= '0;
      best_metric_q <= '0;
      best_ang_q <= '0;
      best_idx_q <= '0;
      ang_out <= '0;
      theta_out <= '0;
      max_out <= '0;
    end else begin
      state_q <= SCAN;
      if (flush) begin
        idx_q <= '0;
        best_metric_q <= '0;
        best_ang_q <= '0;
        best_idx_q <= '0;
      end else if (in_valid) begin
        idx_q <= idx_q + 1'b1;
        best_metric_q <= best_metric_d;
        best_ang_q <= best_ang_d;
        best_idx_q <= best_idx_d;
        if (idx_q == LAST) begin
          state_q <= EMIT;
          ang_out <= best_ang_d;
          theta_out <= best_idx_d;
          max_out <= best_metric_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_argmax_ang.sv
// tb_argmax_ang: directed and randomized checks of argmax_ang with an 8-sample window.
module tb_argmax_ang;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0;
  logic [23:0] metric_in = 0;
  logic signed [12:0] ang_in = 0;
  logic signed [12:0] ang_out;
  logic [2:0] theta_out;
  logic [23:0] max_out;
  logic argmax_valid;
  int compared = 0, mismatched = 0, cyc = 0;
  int bm[8] = '{3, 9, 2, 9, 1, 0, 4, 5};

  argmax_ang #(.N_WIN(8), .MW(24)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .metric_in(metric_in), .ang_in(ang_in), .ang_out(ang_out),
    .theta_out(theta_out), .max_out(max_out), .argmax_valid(argmax_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic f, input logic v, input logic [23:0] m, input logic signed [12:0] a);
    @(negedge clk);
    rst = r; flush = f; in_valid = v; metric_in = m; ang_in = a;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(1, 1, 1, 24'hABCDEF, 13'h0123);
      compared += 4;
      if (argmax_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b expected 0", argmax_valid); end
      if (ang_out !== 13'h0) begin mismatched++; $display("FAIL reset_ang: got %0d expected 0", ang_out); end
      if (theta_out !== 3'd0) begin mismatched++; $display("FAIL reset_theta: got %0d expected 0", theta_out); end
      if (max_out !== 24'd0) begin mismatched++; $display("FAIL reset_max: got %0d expected 0", max_out); end
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 24'(bm[i]), 13'(10 * i));
      compared++;
      if (argmax_valid !== (i == 7)) begin mismatched++; $display("FAIL basic_valid[%0d]: got %0b expected %0b", i, argmax_valid, i == 7); end
    end
    compared += 3;
    if (theta_out !== 3'd1) begin mismatched++; $display("FAIL basic_theta: got %0d expected 1", theta_out); end
    if (ang_out !== 13'sd10) begin mismatched++; $display("FAIL basic_ang: got %0d expected 10", ang_out); end
    if (max_out !== 24'd9) begin mismatched++; $display("FAIL basic_max: got %0d expected 9", max_out); end
    step(0, 0, 0, 24'hFFFFFF, 13'h0777);
    compared += 2;
    if (argmax_valid !== 1'b0) begin mismatched++; $display("FAIL basic_pulse_width: got %0b expected 0", argmax_valid); end
    if (theta_out !== 3'd1 || max_out !== 24'd9) begin mismatched++; $display("FAIL basic_hold: got theta %0d max %0d expected 1 9", theta_out, max_out); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] m2[8];
    logic signed [12:0] a2[8];
    int t1 = -1, t2 = -1, np = 0;
    for (int i = 0; i < 7; i++) begin
      m2[i] = 24'($urandom_range(0, 24'hFFFFFE));
      a2[i] = 13'($urandom);
    end
    m2[7] = 24'hFFFFFF;
    a2[7] = 13'h1000;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) step(0, 0, 1, 24'(bm[i]), 13'(10 * i));
      else step(0, 0, 1, m2[i-8], a2[i-8]);
      if (argmax_valid) begin
        np++;
        if (t1 < 0) t1 = cyc; else t2 = cyc;
        if (i == 7) begin
          compared++;
          if (theta_out !== 3'd1) begin mismatched++; $display("FAIL b2b_theta1: got %0d expected 1", theta_out); end
        end
      end
    end
    compared += 5;
    if (np !== 2) begin mismatched++; $display("FAIL b2b_pulses: got %0d expected 2", np); end
    if (t2 - t1 !== 8) begin mismatched++; $display("FAIL b2b_spacing: got %0d expected 8", t2 - t1); end
    if (theta_out !== 3'd7) begin mismatched++; $display("FAIL b2b_theta2: got %0d expected 7", theta_out); end
    if (ang_out !== 13'h1000) begin mismatched++; $display("FAIL b2b_ang2: got %0d expected -4096", ang_out); end
    if (max_out !== 24'hFFFFFF) begin mismatched++; $display("FAIL b2b_max2: got %0h expected ffffff", max_out); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 24'(bm[i]), 13'(10 * i));
      compared++;
      if (argmax_valid !== (i == 7)) begin mismatched++; $display("FAIL idle_valid[%0d]: got %0b expected %0b", i, argmax_valid, i == 7); end
      if (i == 7) begin
        compared += 3;
        if (theta_out !== 3'd1) begin mismatched++; $display("FAIL idle_theta: got %0d expected 1", theta_out); end
        if (ang_out !== 13'sd10) begin mismatched++; $display("FAIL idle_ang: got %0d expected 10", ang_out); end
        if (max_out !== 24'd9) begin mismatched++; $display("FAIL idle_max: got %0d expected 9", max_out); end
      end
      step(0, 0, 0, 24'hFFFFFF, 13'h0555);
      compared++;
      if (argmax_valid !== 1'b0) begin mismatched++; $display("FAIL idle_gap[%0d]: got %0b expected 0", i, argmax_valid); end
    end
  endtask

  task automatic test_flush();
    logic signed [12:0] a0;
    int np = 0;
    for (int i = 0; i < 4; i++) step(0, 0, 1, 24'hFFFFF0, 13'h0444);
    step(0, 1, 1, 24'hFFFFFF, 13'h0333);
    compared += 2;
    if (argmax_valid !== 1'b0) begin mismatched++; $display("FAIL flush_nopulse: got %0b expected 0", argmax_valid); end
    if (theta_out !== 3'd1 || ang_out !== 13'sd10 || max_out !== 24'd9) begin mismatched++; $display("FAIL flush_hold: got theta %0d ang %0d max %0d expected 1 10 9", theta_out, ang_out, max_out); end
    a0 = 13'($urandom);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 24'd0, i == 0 ? a0 : 13'($urandom));
      if (argmax_valid) np++;
    end
    compared += 4;
    if (np !== 1 || argmax_valid !== 1'b1) begin mismatched++; $display("FAIL flush_pulse: got %0d pulses expected 1 at the last sample", np); end
    if (theta_out !== 3'd0) begin mismatched++; $display("FAIL flush_theta: got %0d expected 0", theta_out); end
    if (ang_out !== a0) begin mismatched++; $display("FAIL flush_ang: got %0d expected %0d", ang_out, a0); end
    if (max_out !== 24'd0) begin mismatched++; $display("FAIL flush_max: got %0d expected 0", max_out); end
  endtask

  task automatic test_flush_edges();
    for (int i = 0; i < 8; i++) step(0, i == 7, 1, 24'(bm[i]), 13'(10 * i));
    compared++;
    if (argmax_valid !== 1'b0) begin mismatched++; $display("FAIL flush_final: got %0b expected 0", argmax_valid); end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 24'(bm[i]), 13'(10 * i));
    compared++;
    if (argmax_valid !== 1'b1) begin mismatched++; $display("FAIL flush_refill: got %0b expected 1", argmax_valid); end
    step(0, 1, 1, 24'hFFFFFF, 13'h0999);
    compared += 2;
    if (argmax_valid !== 1'b0) begin mismatched++; $display("FAIL flush_emit_valid: got %0b expected 0", argmax_valid); end
    if (theta_out !== 3'd1 || max_out !== 24'd9) begin mismatched++; $display("FAIL flush_emit_hold: got theta %0d max %0d expected 1 9", theta_out, max_out); end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 24'(bm[i]), 13'(10 * i));
      compared++;
      if (argmax_valid !== (i == 7)) begin mismatched++; $display("FAIL flush_emit_window[%0d]: got %0b expected %0b", i, argmax_valid, i == 7); end
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 6; i++) step(0, 0, 1, 24'($urandom), 13'($urandom));
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 1, 24'hFFFFFF, 13'h0AAA);
      compared++;
      if (argmax_valid !== 1'b0 || ang_out !== 13'h0 || theta_out !== 3'd0 || max_out !== 24'd0) begin
        mismatched++;
        $display("FAIL rst_mid_zero: got valid %0b ang %0d theta %0d max %0d expected all 0", argmax_valid, ang_out, theta_out, max_out);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 24'(bm[i]), 13'(10 * i));
      compared++;
      if (argmax_valid !== (i == 7)) begin mismatched++; $display("FAIL rst_mid_valid[%0d]: got %0b expected %0b", i, argmax_valid, i == 7); end
    end
    compared++;
    if (theta_out !== 3'd1 || ang_out !== 13'sd10 || max_out !== 24'd9) begin mismatched++; $display("FAIL rst_mid_result: got theta %0d ang %0d max %0d expected 1 10 9", theta_out, ang_out, max_out); end
  endtask

  task automatic test_random();
    logic [23:0] wm[$];
    logic signed [12:0] wa[$];
    logic [23:0] hm = 24'd9;
    logic signed [12:0] ha = 13'sd10;
    int ht = 1, accepted = 0, np = 0, best;
    logic v, exp_pulse;
    logic [23:0] m;
    logic signed [12:0] a;
    while (accepted < 10000) begin
      v = ($urandom_range(0, 3) != 0);
      m = $urandom_range(0, 1) ? 24'($urandom_range(0, 15)) : 24'($urandom);
      a = 13'($urandom);
      step(0, 0, v, m, a);
      exp_pulse = 1'b0;
      if (v) begin
        accepted++;
        wm.push_back(m);
        wa.push_back(a);
        if (wm.size() == 8) begin
          best = 0;
          for (int i = 1; i < 8; i++) if (wm[i] > wm[best]) best = i;
          ht = best; hm = wm[best]; ha = wa[best];
          exp_pulse = 1'b1;
          wm.delete();
          wa.delete();
        end
      end
      if (argmax_valid) np++;
      compared += 2;
      if (argmax_valid !== exp_pulse) begin mismatched++; $display("FAIL rand_valid@%0d: got %0b expected %0b", cyc, argmax_valid, exp_pulse); end
      if (theta_out !== 3'(ht) || ang_out !== ha || max_out !== hm) begin
        mismatched++;
        $display("FAIL rand_outputs@%0d: got theta %0d ang %0d max %0d expected %0d %0d %0d", cyc, theta_out, ang_out, max_out, ht, ha, hm);
      end
    end
    compared++;
    if (np !== accepted / 8) begin mismatched++; $display("FAIL rand_pulse_count: got %0d expected %0d", np, accepted / 8); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_idle();
    test_flush();
    test_flush_edges();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/argmax_ang.md
ARGMAX_ANG -- requirements
Module: argmax_ang

Interface
REQ-001 SHALL have parameter N_WIN, default 256, meaning samples per search window (power of two, 4..1024).
REQ-002 SHALL have parameter MW, default 24, meaning metric width (unsigned magnitude).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, meaning abort the current window and restart at index 0.
REQ-006 SHALL have port in_valid, input, 1, meaning metric_in/ang_in carry a sample this cycle.
REQ-007 SHALL have port metric_in, input, MW, meaning unsigned correlation magnitude of the sample.
REQ-008 SHALL have port ang_in, input, 13 (ang_t, signed Q3.10), meaning correlation phase of the sample.
REQ-009 SHALL have port ang_out, output, 13 (ang_t, Q3.10), meaning phase of the window's maximum-metric sample.
REQ-010 SHALL have port theta_out, output, log2(N_WIN), meaning index within the window of that sample.
REQ-011 SHALL have port max_out, output, MW, meaning the maximum metric value.
REQ-012 SHALL have port argmax_valid, output, 1, meaning a one-cycle pulse marking new ang_out/theta_out/max_out; it feeds the downstream eps-conversion stage directly.

Function
REQ-013 SHALL be always ready: every cycle with in_valid=1 consumes one sample; there is no backpressure.
REQ-014 SHALL keep sample counter idx (0..N_WIN-1) incremented per accepted sample, wrapping to 0 after N_WIN-1.
REQ-015 SHALL, on the sample at idx=0, unconditionally load best_metric, best_ang and best_idx from that sample.
REQ-016 SHALL, on idx>0, replace the best registers only when metric_in > best_metric (strict); ties keep the earliest index.
REQ-017 SHALL, in the cycle after the sample at idx=N_WIN-1 is accepted, pulse argmax_valid=1 for exactly one cycle. The best registers used are updated by that final sample.
REQ-018 SHALL hold ang_out, theta_out and max_out stable from the pulse until the next pulse.
REQ-019 SHALL treat a sample accepted in the pulse cycle as idx=0 of the next window, so back-to-back windows run with no gap cycles.
REQ-020 SHALL use two states. SCAN covers idx 0..N_WIN-1. EMIT is the single pulse cycle, is entered from SCAN on the final sample, and always returns to SCAN.
REQ-021 SHALL pass idle cycles (in_valid=0) with no change to idx or the best registers; samples need not be contiguous.
REQ-022 SHALL, on flush=1, set idx=0 and discard partial best values, with no pulse for the aborted window. Any in_valid sample in the same cycle is dropped. Outputs keep their previous values.
REQ-023 SHALL give flush priority over completing a window: flush together with the final sample produces no pulse.
REQ-024 SHALL give a flush during the EMIT cycle no effect on that pulse; it only clears idx and discards the sample in that cycle.
REQ-025 SHALL pass ang_in bits through unmodified, with no arithmetic on angles.

Reset
REQ-026 SHALL, while rst=1, set argmax_valid=0, ang_out=0, theta_out=0, max_out=0, idx=0, best registers=0 and state=SCAN. rst has priority over flush and in_valid.
REQ-027 SHALL, on rst mid-window, discard partial results. The first sample after deassertion is idx=0 and no pulse is generated for the interrupted window.

Verification
REQ-028 SHALL cover this case: N_WIN=8, contiguous metrics 3,9,2,9,1,0,4,5 with ang_in=10*idx gives one pulse, 1 cycle after the 8th sample, with theta_out=1, ang_out=10, max_out=9 (tie keeps earliest).
REQ-029 SHALL cover this case: two back-to-back windows, the second with its max at idx 7 (metric 2^MW-1, ang_in=-4096) gives a second pulse exactly 8 cycles after the first, with theta_out=7 and ang_out=-4096.
REQ-030 SHALL cover this case: the 8 samples of REQ-028 with one idle cycle after every sample give identical outputs, with the pulse 1 cycle after the 8th accepted sample.
REQ-031 SHALL cover this case: flush asserted with the 5th sample, then 8 new samples with all metrics 0 gives exactly one pulse, with theta_out=0 and ang_out equal to the first new sample's angle.
REQ-032 SHALL cover this case: rst pulsed after 6 samples, then a full window gives all outputs 0 during reset and one pulse only after 8 post-reset samples.
REQ-033 SHALL cover this case: a random 10k-sample stream checked against a reference model gives pulse count = floor(accepted/N_WIN) and exact theta/ang/max per window.
